// File: rtl/mem_pkg.sv
// Shared types and default sizes for the inbound memory subsystem.
package mem_pkg;

    localparam int DEF_NUM_REQ = 8;
    localparam int DEF_DATA_W  = 128;
    localparam int DEF_ADDR_W  = 32;

    typedef enum logic {
        IDLE,
        BURST
    } wr_arb_state_t;

    typedef logic [$clog2(DEF_NUM_REQ)-1:0] req_idx_t;

endpackage

// File: rtl/ib_wr_arbiter_rr_pick.sv
// Round-robin picker: first set request at or above ptr, wrapping modulo N.
// Purely combinational; zero latency, no backpressure.
module rr_pick #(
    parameter int N = 8
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic [N-1:0]         win_oh,
    output logic [$clog2(N)-1:0] win_idx,
    output logic                 found
);

    localparam int IW = $clog2(N);

    logic [IW-1:0] cand;

    always_comb begin
        cand    = '0;
        win_idx = '0;
        found   = 1'b0;
        for (int i = 0; i < N; i++) begin
            cand = ptr + IW'(i);
            if (!found && req[cand]) begin
                found   = 1'b1;
                win_idx = cand;
            end
        end
        win_oh = found ? (N'(1) << win_idx) : '0;
    end

endmodule

// File: rtl/ib_wr_arbiter.sv
// Round-robin arbiter with burst locking onto the inbound RAM write port.
// One register stage to WrEn/WrAddr/WrData; ReqReady is combinational from state.
module ib_wr_arbiter
    import mem_pkg::*;
#(
    parameter int NUM_REQ   = DEF_NUM_REQ,
    parameter int DATA_W    = DEF_DATA_W,
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int MAX_BEATS = 16
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [NUM_REQ-1:0]               ReqValid,
    input  logic [NUM_REQ-1:0][DATA_W-1:0]   ReqData,
    input  logic [NUM_REQ-1:0][ADDR_W-1:0]   ReqAddr,
    input  logic [NUM_REQ-1:0]               ReqLast,
    output logic [NUM_REQ-1:0]               ReqReady,
    output logic                             WrEn,
    output logic [ADDR_W-1:0]                WrAddr,
    output logic [DATA_W-1:0]                WrData,
    output logic [$clog2(NUM_REQ)-1:0]       GrantId,
    output logic                             Busy
);

    localparam int  IDX_W    = $clog2(NUM_REQ);
    localparam int  CNT_W    = $clog2(MAX_BEATS + 1);
    localparam bit  ONE_BEAT = (MAX_BEATS == 1);

    wr_arb_state_t      state_q, state_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [IDX_W-1:0]   gnt_q, gnt_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               wr_en_q, wr_en_d;
    logic [ADDR_W-1:0]  wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0]  wr_data_q, wr_data_d;

    logic [NUM_REQ-1:0] win_oh;
    logic [IDX_W-1:0]   win_idx;
    logic               found;
    logic [IDX_W-1:0]   sel_idx;
    logic [CNT_W-1:0]   cnt_inc;
    logic               accept;
    logic               beat_last;

    rr_pick #(.N(NUM_REQ)) u_pick (
        .req     (ReqValid),
        .ptr     (ptr_q),
        .win_oh  (win_oh),
        .win_idx (win_idx),
        .found   (found)
    );

    always_comb begin
        sel_idx  = (state_q == IDLE) ? win_idx : gnt_q;
        ReqReady = '0;
        if (rst_n) begin
            if (state_q == IDLE) begin
                ReqReady = found ? win_oh : '0;
            end else begin
                ReqReady[gnt_q] = 1'b1;
            end
        end
        accept    = |(ReqValid & ReqReady);
        beat_last = ReqLast[sel_idx];
        cnt_inc   = cnt_q + CNT_W'(1);

        state_d   = state_q;
        ptr_d     = ptr_q;
        gnt_d     = gnt_q;
        cnt_d     = cnt_q;
        wr_en_d   = accept;
        wr_addr_d = accept ? ReqAddr[sel_idx] : wr_addr_q;
        wr_data_d = accept ? ReqData[sel_idx] : wr_data_q;

        case (state_q)
            IDLE: begin
                // The arbitration cycle carries the winner's first beat.
                if (accept) begin
                    gnt_d = win_idx;
                    cnt_d = CNT_W'(1);
                    if (beat_last || ONE_BEAT) begin
                        ptr_d = win_idx + IDX_W'(1);
                    end else begin
                        state_d = BURST;
                    end
                end
            end
            BURST: begin
                if (accept) begin
                    cnt_d = cnt_inc;
                    if (beat_last || (cnt_inc == CNT_W'(MAX_BEATS))) begin
                        state_d = IDLE;
                        ptr_d   = gnt_q + IDX_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            gnt_q     <= '0;
            cnt_q     <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            gnt_q     <= gnt_d;
            cnt_q     <= cnt_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    assign WrEn    = wr_en_q;
    assign WrAddr  = wr_addr_q;
    assign WrData  = wr_data_q;
    assign GrantId = gnt_q;
    assign Busy    = (state_q == BURST);

endmodule

// File: doc/ib_wr_arbiter.md
# ib_wr_arbiter

Shares the single 128-bit write port of the inbound RAM among `NUM_REQ` write requesters, such as PCIe RX completion engines and the AXI write path. Arbitration is round-robin with burst locking and a forced rotation after `MAX_BEATS` accepted beats. The block sits between the requesters and the inbound RAM instance inside the memory subsystem, and drives `WrEn`/`WrAddr`/`WrData` through one register stage.

## Interface
- `NUM_REQ`, 8: number of requesters; power of two, 2..16.
- `DATA_W`, 128: beat width.
- `ADDR_W`, 32: RAM address width.
- `MAX_BEATS`, 16: maximum beats per grant before forced rotation; 1..256.

Ports:
- `clk`  in  1: single clock.
- `rst_n`  in  1: reset, synchronous, active-low.
- `ReqValid`  in  `[NUM_REQ-1:0]`: per-requester beat valid.
- `ReqData`  in  `[NUM_REQ-1:0][DATA_W-1:0]`: beat data.
- `ReqAddr`  in  `[NUM_REQ-1:0][ADDR_W-1:0]`: beat address, passed through unmodified.
- `ReqLast`  in  `[NUM_REQ-1:0]`: last beat of the requester's burst.
- `ReqReady`  out  `[NUM_REQ-1:0]`: beat accepted when `ReqValid & ReqReady`.
- `WrEn`  out  1: RAM write enable.
- `WrAddr`  out  `ADDR_W`: RAM write address.
- `WrData`  out  `DATA_W`: RAM write data.
- `GrantId`  out  `$clog2(NUM_REQ)`: current or last granted requester.
- `Busy`  out  1: high while in BURST.

## Operation
- States are IDLE and BURST. Registers: `ptr` (round-robin start index), `gnt` (granted index), `cnt` (beats accepted in the current grant, 0..MAX_BEATS).
- **IDLE:**
  - Pick the first requester with `ReqValid` high, searching from `ptr` upward with modulo wrap.
  - Assert `ReqReady` for the winner only, in the same cycle, so its first beat is accepted in the arbitration cycle.
  - Load `gnt`=winner and `cnt`=1.
  - If the accepted beat has `ReqLast`, or `MAX_BEATS`==1: stay in IDLE, set `ptr`=winner+1.
  - Otherwise go to BURST.
- **BURST:**
  - `ReqReady[gnt]`=1; every other bit is 0.
  - Each accepted beat increments `cnt`.
  - If `ReqValid[gnt]` drops, the grant is held, nothing is written, and `cnt` is unchanged.
  - An accepted beat with `ReqLast`, or the accepted beat that brings `cnt` to `MAX_BEATS`, goes to IDLE with `ptr`=`gnt`+1.
  - A requester rotated out by `MAX_BEATS` re-arbitrates for its remaining beats.
- Other requesters' `ReqLast` is ignored.
- `ReqReady` is never asserted for a requester whose `ReqValid` is low in IDLE.
- `ptr` wraps modulo `NUM_REQ`: `gnt`=NUM_REQ-1 gives `ptr`=0.
- When all requesters are valid continuously, each gets at most `MAX_BEATS` beats per round. Maximum starvation is (NUM_REQ-1)*MAX_BEATS cycles.

## Timing
- Reset values: `WrEn`=0, `WrAddr`=0, `WrData`=0, `ReqReady`=0, `GrantId`=0, `Busy`=0, `ptr`=0, `cnt`=0, state IDLE.
- `ReqReady` is combinational from state and `ReqValid`, and is forced to 0 while `rst_n`=0.
- Latency: a beat accepted in cycle N appears as `WrEn`=1 with its `ReqAddr`/`ReqData` in cycle N+1.
- `WrEn`=0 in any cycle following no acceptance. `WrAddr`/`WrData` hold their previous values when `WrEn`=0.
- Throughput is one beat per cycle, with no bubble between grants: the IDLE arbitration cycle itself carries a beat.
- `GrantId` updates in the cycle after the arbitration decision. `Busy` is registered and high in every BURST cycle.
- Reset mid-burst: the burst is abandoned, and no write appears in the cycle after reset assertion.

## Structure
- Package `mem_pkg`:
  - localparams for default `NUM_REQ`, `DATA_W`, `ADDR_W`;
  - `typedef enum logic {IDLE, BURST} wr_arb_state_t`;
  - `typedef logic [$clog2(NUM_REQ)-1:0] req_idx_t`.
- Sub-module `rr_pick`: purely combinational. Inputs are the request vector and `ptr`; outputs are a one-hot winner, the winner's index, and a `found` flag.
- The top level holds the FSM, the counters, the output register and the data mux.

## Test plan
- **Single requester.** Requester 3 sends 4 beats at addresses 0x100..0x103 with data 0xA0..0xA3, `ReqLast` on the 4th. Expect `WrEn` for 4 consecutive cycles starting 1 cycle after the first `ReqValid`, data and addresses in order, `GrantId`=3, `ptr`=4.
- **Fairness.** Requesters 0, 2 and 7 each hold valid with 2-beat bursts. Expect grant order 0, 2, 7, 0 with no idle cycle between bursts.
- **Forced rotation.** `MAX_BEATS`=16; requester 1 sends a 20-beat burst while requester 5 is waiting. Expect 16 beats from 1, then 5's burst, then 1's remaining 4 beats.
- **Stall.** Requester 4 drops `ReqValid` for 3 cycles mid-burst while requester 6 is valid. Expect `ReqReady[6]`=0 throughout, `WrEn`=0 for 3 cycles, and requester 4's burst completing afterwards.
- **Wrap.** `ptr`=7 with requesters 7 and 0 valid. Expect 7, then 0.
- **Reset mid-burst.** Assert `rst_n`=0 during beat 2 of 8. Expect all outputs at reset values the next cycle, and on release arbitration restarting from `ptr`=0.
